// File: rtl/sha2_k_sequencer.sv
// sha2_k_sequencer: per-block SHA-2 round-constant source.
// Valid/ready semantics: k/round are offered while k_valid is high; the
// consumer takes the current constant in any cycle with k_valid & advance,
// and the next constant appears on the following cycle. With advance low
// the offer holds indefinitely. start restarts the block at round 0 and has
// priority over advance.
module sha2_k_sequencer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              advance,
    output logic [WORD_W-1:0] k,
    output logic              k_valid,
    output logic [6:0]        round,
    output logic              last,
    output logic              done,
    output logic              busy
);

    localparam int         ROUNDS   = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha2_k_sequencer: WORD_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] k_nxt;
    logic [6:0]        round_nxt;
    logic              last_nxt;
    logic              done_nxt;
    logic [6:0]        rom_idx;
    logic [63:0]       rom_full;
    logic [WORD_W-1:0] rom_k;

    // SHA-512 constants; the SHA-256 constants are the upper 32 bits of
    // the first 64 entries, so one table serves both widths.
    function automatic logic [63:0] k512_rom(input logic [6:0] idx);
        logic [63:0] v;
        case (idx)
            7'd0:  v = 64'h428a2f98d728ae22;  7'd1:  v = 64'h7137449123ef65cd;
            7'd2:  v = 64'hb5c0fbcfec4d3b2f;  7'd3:  v = 64'he9b5dba58189dbbc;
            7'd4:  v = 64'h3956c25bf348b538;  7'd5:  v = 64'h59f111f1b605d019;
            7'd6:  v = 64'h923f82a4af194f9b;  7'd7:  v = 64'hab1c5ed5da6d8118;
            7'd8:  v = 64'hd807aa98a3030242;  7'd9:  v = 64'h12835b0145706fbe;
            7'd10: v = 64'h243185be4ee4b28c;  7'd11: v = 64'h550c7dc3d5ffb4e2;
            7'd12: v = 64'h72be5d74f27b896f;  7'd13: v = 64'h80deb1fe3b1696b1;
            7'd14: v = 64'h9bdc06a725c71235;  7'd15: v = 64'hc19bf174cf692694;
            7'd16: v = 64'he49b69c19ef14ad2;  7'd17: v = 64'hefbe4786384f25e3;
            7'd18: v = 64'h0fc19dc68b8cd5b5;  7'd19: v = 64'h240ca1cc77ac9c65;
            7'd20: v = 64'h2de92c6f592b0275;  7'd21: v = 64'h4a7484aa6ea6e483;
            7'd22: v = 64'h5cb0a9dcbd41fbd4;  7'd23: v = 64'h76f988da831153b5;
            7'd24: v = 64'h983e5152ee66dfab;  7'd25: v = 64'ha831c66d2db43210;
            7'd26: v = 64'hb00327c898fb213f;  7'd27: v = 64'hbf597fc7beef0ee4;
            7'd28: v = 64'hc6e00bf33da88fc2;  7'd29: v = 64'hd5a79147930aa725;
            7'd30: v = 64'h06ca6351e003826f;  7'd31: v = 64'h142929670a0e6e70;
            7'd32: v = 64'h27b70a8546d22ffc;  7'd33: v = 64'h2e1b21385c26c926;
            7'd34: v = 64'h4d2c6dfc5ac42aed;  7'd35: v = 64'h53380d139d95b3df;
            7'd36: v = 64'h650a73548baf63de;  7'd37: v = 64'h766a0abb3c77b2a8;
            7'd38: v = 64'h81c2c92e47edaee6;  7'd39: v = 64'h92722c851482353b;
            7'd40: v = 64'ha2bfe8a14cf10364;  7'd41: v = 64'ha81a664bbc423001;
            7'd42: v = 64'hc24b8b70d0f89791;  7'd43: v = 64'hc76c51a30654be30;
            7'd44: v = 64'hd192e819d6ef5218;  7'd45: v = 64'hd69906245565a910;
            7'd46: v = 64'hf40e35855771202a;  7'd47: v = 64'h106aa07032bbd1b8;
            7'd48: v = 64'h19a4c116b8d2d0c8;  7'd49: v = 64'h1e376c085141ab53;
            7'd50: v = 64'h2748774cdf8eeb99;  7'd51: v = 64'h34b0bcb5e19b48a8;
            7'd52: v = 64'h391c0cb3c5c95a63;  7'd53: v = 64'h4ed8aa4ae3418acb;
            7'd54: v = 64'h5b9cca4f7763e373;  7'd55: v = 64'h682e6ff3d6b2b8a3;
            7'd56: v = 64'h748f82ee5defb2fc;  7'd57: v = 64'h78a5636f43172f60;
            7'd58: v = 64'h84c87814a1f0ab72;  7'd59: v = 64'h8cc702081a6439ec;
            7'd60: v = 64'h90befffa23631e28;  7'd61: v = 64'ha4506cebde82bde9;
            7'd62: v = 64'hbef9a3f7b2c67915;  7'd63: v = 64'hc67178f2e372532b;
            7'd64: v = 64'hca273eceea26619c;  7'd65: v = 64'hd186b8c721c0c207;
            7'd66: v = 64'heada7dd6cde0eb1e;  7'd67: v = 64'hf57d4f7fee6ed178;
            7'd68: v = 64'h06f067aa72176fba;  7'd69: v = 64'h0a637dc5a2c898a6;
            7'd70: v = 64'h113f9804bef90dae;  7'd71: v = 64'h1b710b35131c471b;
            7'd72: v = 64'h28db77f523047d84;  7'd73: v = 64'h32caab7b40c72493;
            7'd74: v = 64'h3c9ebe0a15c9bebc;  7'd75: v = 64'h431d67c49c100d4c;
            7'd76: v = 64'h4cc5d4becb3e42b6;  7'd77: v = 64'h597f299cfc657e2a;
            7'd78: v = 64'h5fcb6fab3ad6faec;  7'd79: v = 64'h6c44198c4a475817;
            default: v = 64'h0;
        endcase
        return v;
    endfunction

    // ROM lookup for the constant loaded next: K[0] on start, else K[round+1].
    always_comb begin
        rom_idx  = start ? 7'd0 : (round + 7'd1);
        rom_full = k512_rom(rom_idx);
        rom_k    = (rom_idx < LAST_RND + 7'd1) ? rom_full[63 -: WORD_W] : '0;
    end

    // Next-state and next-output logic; start outranks advance in RUN.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        round_nxt = round;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    round_nxt = 7'd0;
                    k_nxt     = rom_k;
                end
            end
            RUN: begin
                if (start) begin
                    round_nxt = 7'd0;
                    k_nxt     = rom_k;
                    done_nxt  = advance && (round == LAST_RND);
                end else if (advance) begin
                    if (round == LAST_RND) begin
                        state_nxt = IDLE;
                        round_nxt = 7'd0;
                        k_nxt     = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        round_nxt = round + 7'd1;
                        k_nxt     = rom_k;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        last_nxt = (state_nxt == RUN) && (round_nxt == LAST_RND);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            k_valid <= 1'b0;
            round   <= 7'd0;
            last    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            k_valid <= (state_nxt == RUN);
            round   <= round_nxt;
            last    <= last_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Bench for sha2_k_sequencer: one SHA-256 and one SHA-512 instance.
module tb_sha2_k_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, adv32 = 1'b0, start64 = 1'b0, adv64 = 1'b0;
    logic [31:0] k32;
    logic [63:0] k64;
    logic        kv32, last32, done32, busy32;
    logic        kv64, last64, done64, busy64;
    logic [6:0]  round32, round64;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    logic [31:0] k256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic [63:0] k512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    typedef struct {
        logic        rst_n, start, adv;
        logic        e_kv;
        logic [6:0]  e_round;
        logic        e_last, e_done, e_busy;
        logic [31:0] e_k;
    } vec_t;
    vec_t vecs [10];

    sha2_k_sequencer #(.WORD_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .advance(adv32),
        .k(k32), .k_valid(kv32), .round(round32), .last(last32), .done(done32), .busy(busy32));

    sha2_k_sequencer #(.WORD_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .advance(adv64),
        .k(k64), .k_valid(kv64), .round(round64), .last(last64), .done(done64), .busy(busy64));

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required summary before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic e_kv, input logic [6:0] e_round,
                         input logic e_last, input logic e_done, input logic e_busy,
                         input logic [31:0] e_k);
        chk({tag, "_kv"},    64'(kv32),    64'(e_kv));
        chk({tag, "_round"}, 64'(round32), 64'(e_round));
        chk({tag, "_last"},  64'(last32),  64'(e_last));
        chk({tag, "_done"},  64'(done32),  64'(e_done));
        chk({tag, "_busy"},  64'(busy32),  64'(e_busy));
        chk({tag, "_k"},     64'(k32),     64'(e_k));
    endtask

    task automatic chk64_idle(input string tag);
        chk({tag, "_kv64"},    64'(kv64),    64'd0);
        chk({tag, "_round64"}, 64'(round64), 64'd0);
        chk({tag, "_last64"},  64'(last64),  64'd0);
        chk({tag, "_done64"},  64'(done64),  64'd0);
        chk({tag, "_busy64"},  64'(busy64),  64'd0);
        chk({tag, "_k64"},     k64,          64'd0);
    endtask

    initial begin
        logic [63:0] cur_k;
        int          idx;
        logic        fired_last;

        // {rst_n, start, adv, kv, round, last, done, busy, k} from idle
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 32'h428a2f98};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 32'h428a2f98};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b1, 32'h71374491};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd1, 1'b0, 1'b0, 1'b1, 32'h71374491};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd2, 1'b0, 1'b0, 1'b1, 32'hb5c0fbcf};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 32'h428a2f98};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b1, 32'h71374491};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0};

        // reset held with start/advance high, then released
        rst_n = 1'b0; start32 = 1'b1; adv32 = 1'b1; start64 = 1'b1; adv64 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk32("rst_hold", 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk64_idle("rst_hold");
        end
        rst_n = 1'b1; start32 = 1'b0; adv32 = 1'b0; start64 = 1'b0; adv64 = 1'b0;
        step();
        chk32("rst_rel", 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk64_idle("rst_rel");

        // table-driven short sequences
        for (int i = 0; i < 10; i++) begin
            rst_n = vecs[i].rst_n; start32 = vecs[i].start; adv32 = vecs[i].adv;
            step();
            chk32($sformatf("vec%0d", i), vecs[i].e_kv, vecs[i].e_round, vecs[i].e_last,
                  vecs[i].e_done, vecs[i].e_busy, vecs[i].e_k);
        end
        rst_n = 1'b1; start32 = 1'b0; adv32 = 1'b0;

        // SHA-256 full unstalled block
        start32 = 1'b1;
        for (int i = 0; i < 64; i++) exp_q.push_back(64'(k256[i]));
        step();
        start32 = 1'b0; adv32 = 1'b1;
        for (int c = 0; c < 64; c++) begin
            cur_k = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead;
            chk32($sformatf("blk32_c%0d", c + 1), 1'b1, 7'(c), (c == 63), 1'b0, 1'b1, cur_k[31:0]);
            if (c == 0)  chk("blk32_k0_lit",  64'(k32), 64'h428a2f98);
            if (c == 1)  chk("blk32_k1_lit",  64'(k32), 64'h71374491);
            if (c == 63) chk("blk32_k63_lit", 64'(k32), 64'hc67178f2);
            step();
        end
        chk32("blk32_done", 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        adv32 = 1'b0;
        step();
        chk32("blk32_after", 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);

        // SHA-512 full block with random stalls
        exp_q.delete();
        start64 = 1'b1;
        for (int i = 0; i < 80; i++) exp_q.push_back(k512[i]);
        step();
        start64 = 1'b0;
        idx = 0; fired_last = 1'b0;
        cur_k = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (fired_last) break;
            chk("blk64_done_lo", 64'(done64), 64'd0);
            chk("blk64_round", 64'(round64), 64'(idx));
            chk("blk64_last", 64'(last64), 64'(idx == 79));
            chk("blk64_k", k64, cur_k);
            adv64 = ($urandom_range(0, 3) != 0);
            if (adv64) begin
                if (idx == 79) fired_last = 1'b1;
                else begin
                    idx++;
                    if (exp_q.size() > 0) cur_k = exp_q.pop_front();
                    else chk("blk64_q_underflow", 64'(exp_q.size()), 64'd1);
                end
            end
            step();
        end
        chk("blk64_finished", 64'(fired_last), 64'd1);
        chk("blk64_idx_end", 64'(idx), 64'd79);
        chk("blk64_q_empty", 64'(exp_q.size()), 64'd0);
        chk("blk64_done", 64'(done64), 64'd1);
        chk("blk64_kv_off", 64'(kv64), 64'd0);
        chk("blk64_k_clr", k64, 64'd0);
        adv64 = 1'b0;
        step();
        chk64_idle("blk64_after");

        // restart mid-block at round 17
        start32 = 1'b1; adv32 = 1'b0;
        step();
        start32 = 1'b0; adv32 = 1'b1;
        repeat (17) step();
        chk32("pre_restart", 1'b1, 7'd17, 1'b0, 1'b0, 1'b1, k256[17]);
        start32 = 1'b1; adv32 = 1'b1;
        step();
        chk32("restart", 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, k256[0]);
        start32 = 1'b0; adv32 = 1'b1;
        for (int i = 0; i < 63; i++) begin
            step();
            chk("restart_no_done", 64'(done32), 64'd0);
        end

        // back-to-back: start with the final advance
        chk32("pre_b2b", 1'b1, 7'd63, 1'b1, 1'b0, 1'b1, k256[63]);
        start32 = 1'b1; adv32 = 1'b1;
        step();
        chk32("b2b", 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, k256[0]);
        start32 = 1'b0; adv32 = 1'b1;
        step();
        chk32("b2b_next", 1'b1, 7'd1, 1'b0, 1'b0, 1'b1, k256[1]);

        // reset mid-block at round 40 with advance high
        repeat (39) step();
        chk32("pre_rst", 1'b1, 7'd40, 1'b0, 1'b0, 1'b1, k256[40]);
        rst_n = 1'b0;
        step();
        chk32("mid_rst", 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            chk("post_rst_done", 64'(done32), 64'd0);
            chk("post_rst_busy", 64'(busy32), 64'd0);
        end
        adv32 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
